// File: rtl/l2_eviction_buffer.sv
// Write-back victim buffer between the L2 cache and physical memory.
// Victim lines are absorbed in one cycle and drained to pmem when L2 is quiet;
// L2 reads are forwarded from buffered lines or passed through to pmem.
module l2_eviction_buffer #(
   parameter int unsigned DEPTH = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         l2_read,
   input  logic         l2_write,
   input  logic [15:0]  l2_address,
   input  logic [127:0] l2_wdata,
   output logic [127:0] l2_rdata,
   output logic         l2_resp,
   output logic         pmem_read,
   output logic         pmem_write,
   output logic [15:0]  pmem_address,
   output logic [127:0] pmem_wdata,
   input  logic [127:0] pmem_rdata,
   input  logic         pmem_resp,
   output logic         buf_empty
);

   localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {IDLE, PMEM_READ, PMEM_WRITE, RESP} state_t;

   state_t         state, state_next;
   logic [DEPTH-1:0] valid;
   logic [11:0]    addr [DEPTH];
   logic [127:0]   data [DEPTH];

   logic           hit, full;
   logic [IW-1:0]  hit_idx, free_idx;
   logic           fwd, miss, merge, enq, drain, pop, capture;

   // Byte offset within the line is irrelevant to a line buffer.
   logic unused_offset;
   assign unused_offset = ^l2_address[3:0];

   assign buf_empty  = ~|valid;
   assign full       = &valid;
   assign pmem_read  = (state == PMEM_READ);
   assign pmem_write = (state == PMEM_WRITE);
   assign l2_resp    = (state == RESP);

   // Line-address match against valid entries and first free slot (entries stay packed at the low indices).
   always_comb begin
      hit      = 1'b0;
      hit_idx  = '0;
      free_idx = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (valid[i] && (addr[i] == l2_address[15:4]) && !hit) begin
            hit     = 1'b1;
            hit_idx = IW'(i);
         end
      end
      for (int unsigned i = DEPTH; i > 0; i--) begin
         if (!valid[i-1]) free_idx = IW'(i-1);
      end
   end

   // Next-state and action decode; IDLE serves L2 ahead of draining.
   always_comb begin
      state_next = state;
      fwd        = 1'b0;
      miss       = 1'b0;
      merge      = 1'b0;
      enq        = 1'b0;
      drain      = 1'b0;
      pop        = 1'b0;
      capture    = 1'b0;
      case (state)
         IDLE: begin
            if (l2_read) begin
               if (hit) begin
                  fwd        = 1'b1;
                  state_next = RESP;
               end else begin
                  miss       = 1'b1;
                  state_next = PMEM_READ;
               end
            end else if (l2_write && hit) begin
               merge      = 1'b1;
               state_next = RESP;
            end else if (l2_write && !full) begin
               enq        = 1'b1;
               state_next = RESP;
            end else if (!buf_empty) begin
               drain      = 1'b1;
               state_next = PMEM_WRITE;
            end
         end
         PMEM_READ: begin
            if (pmem_resp) begin
               capture    = 1'b1;
               state_next = RESP;
            end
         end
         PMEM_WRITE: begin
            if (pmem_resp) begin
               pop        = 1'b1;
               state_next = IDLE;
            end
         end
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Registered data/address outputs; l2_rdata holds between responses.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         l2_rdata     <= '0;
         pmem_address <= '0;
         pmem_wdata   <= '0;
      end else begin
         if (fwd)     l2_rdata <= data[hit_idx];
         if (capture) l2_rdata <= pmem_rdata;
         if (miss)    pmem_address <= {l2_address[15:4], 4'h0};
         if (drain) begin
            pmem_address <= {addr[0], 4'h0};
            pmem_wdata   <= data[0];
         end
      end
   end

   // Valid bits: enqueue at first free slot, shift down on head pop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid <= '0;
      end else begin
         if (enq) valid[free_idx] <= 1'b1;
         if (pop) begin
            for (int unsigned i = 0; i + 1 < DEPTH; i++) valid[i] <= valid[i+1];
            valid[DEPTH-1] <= 1'b0;
         end
      end
   end

   // Entry payload: merge in place, enqueue at tail, shift toward the head on pop.
   always_ff @(posedge clk) begin
      if (merge) data[hit_idx] <= l2_wdata;
      if (enq) begin
         addr[free_idx] <= l2_address[15:4];
         data[free_idx] <= l2_wdata;
      end
      if (pop) begin
         for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
            addr[i] <= addr[i+1];
            data[i] <= data[i+1];
         end
      end
   end

endmodule
